// File: rtl/ariane_pkg.sv
// Shared core types and sizes used by the writeback path.
package ariane_pkg;

    localparam int unsigned NR_WB_PORTS   = 3;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

endpackage

// File: rtl/rr_arb_tree.sv
// Rotating-priority arbiter: first request at or after ptr_i wins, wrapping at NumIn-1.
// A constant zero pointer turns it into a fixed lowest-index-wins arbiter.
module rr_arb_tree #(
    parameter int unsigned NumIn = 3,
    parameter int unsigned IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic [NumIn-1:0] req_i,
    input  logic [IdxW-1:0]  ptr_i,
    output logic [NumIn-1:0] gnt_o,
    output logic [IdxW-1:0]  idx_o
);

    int unsigned base;
    int unsigned c;
    logic [IdxW-1:0] cand;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        c     = 0;
        // Out-of-range pointers fall back to index 0.
        base  = (32'(ptr_i) < NumIn) ? 32'(ptr_i) : 0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            c = base + k;
            if (c >= NumIn) begin
                c = c - NumIn;
            end
            cand = IdxW'(c);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// One-entry-per-port writeback buffer arbitrated onto a single scoreboard write port.
// Define WB_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module wb_arbiter
    import ariane_pkg::*;
#(
    parameter int unsigned NR_PORTS = NR_WB_PORTS
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    flush_i,
    input  logic [NR_PORTS-1:0]                     fu_valid_i,
    input  logic [NR_PORTS-1:0][TRANS_ID_BITS-1:0]  fu_trans_id_i,
    input  logic [NR_PORTS-1:0][63:0]               fu_result_i,
    input  exception_t [NR_PORTS-1:0]               fu_ex_i,
    output logic [NR_PORTS-1:0]                     fu_ready_o,
    output logic                                    wb_valid_o,
    output logic [TRANS_ID_BITS-1:0]                wb_trans_id_o,
    output logic [63:0]                             wb_result_o,
    output exception_t                              wb_ex_o,
    input  logic                                    wb_ready_i
);

    localparam int unsigned IdxW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    logic [NR_PORTS-1:0]                    buf_valid_q, buf_valid_d;
    logic [NR_PORTS-1:0][TRANS_ID_BITS-1:0] buf_tid_q, buf_tid_d;
    logic [NR_PORTS-1:0][63:0]              buf_res_q, buf_res_d;
    exception_t [NR_PORTS-1:0]              buf_ex_q, buf_ex_d;

    // While the scoreboard stalls, the arbiter is pinned to the waiting entry.
    logic            lock_q, lock_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;

    logic [IdxW-1:0]     arb_ptr;
    logic [NR_PORTS-1:0] grant;
    logic [IdxW-1:0]     grant_idx;
    logic                pop;

`ifdef WB_ARB_FIXED_PRIO_EN
    assign arb_ptr = lock_q ? lock_idx_q : '0;
`else
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

    assign arb_ptr = lock_q ? lock_idx_q : rr_ptr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (pop && !flush_i) begin
            rr_ptr_d = (grant_idx == IdxW'(NR_PORTS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    rr_arb_tree #(
        .NumIn (NR_PORTS),
        .IdxW  (IdxW)
    ) u_arb (
        .req_i (buf_valid_q),
        .ptr_i (arb_ptr),
        .gnt_o (grant),
        .idx_o (grant_idx)
    );

    assign wb_valid_o = |buf_valid_q;
    assign pop        = wb_valid_o & wb_ready_i;
    assign fu_ready_o = ~buf_valid_q | (grant & {NR_PORTS{wb_ready_i}});

    always_comb begin
        wb_trans_id_o = '0;
        wb_result_o   = '0;
        wb_ex_o       = '0;
        if (wb_valid_o) begin
            wb_trans_id_o = buf_tid_q[grant_idx];
            wb_result_o   = buf_res_q[grant_idx];
            wb_ex_o       = buf_ex_q[grant_idx];
        end
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tid_d   = buf_tid_q;
        buf_res_d   = buf_res_q;
        buf_ex_d    = buf_ex_q;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            if (flush_i) begin
                buf_valid_d[i] = 1'b0;
            end else if (fu_valid_i[i] && fu_ready_o[i]) begin
                buf_valid_d[i] = 1'b1;
                buf_tid_d[i]   = fu_trans_id_i[i];
                buf_res_d[i]   = fu_result_i[i];
                buf_ex_d[i]    = fu_ex_i[i];
            end else if (pop && grant[i]) begin
                buf_valid_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        lock_d     = wb_valid_o && !wb_ready_i && !flush_i;
        lock_idx_d = grant_idx;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid_q <= '0;
            buf_tid_q   <= '0;
            buf_res_q   <= '0;
            buf_ex_q    <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tid_q   <= buf_tid_d;
            buf_res_q   <= buf_res_d;
            buf_ex_q    <= buf_ex_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus an expected-writeback queue.
module tb_wb_arbiter;
    import ariane_pkg::*;

    localparam int unsigned N = NR_WB_PORTS;

    logic                              clk_i = 1'b0;
    logic                              rst_ni;
    logic                              flush_i;
    logic [N-1:0]                      fu_valid_i;
    logic [N-1:0][TRANS_ID_BITS-1:0]   fu_trans_id_i;
    logic [N-1:0][63:0]                fu_result_i;
    exception_t [N-1:0]                fu_ex_i;
    logic [N-1:0]                      fu_ready_o;
    logic                              wb_valid_o;
    logic [TRANS_ID_BITS-1:0]          wb_trans_id_o;
    logic [63:0]                       wb_result_o;
    exception_t                        wb_ex_o;
    logic                              wb_ready_i;

    wb_arbiter #(
        .NR_PORTS (N)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .fu_valid_i    (fu_valid_i),
        .fu_trans_id_i (fu_trans_id_i),
        .fu_result_i   (fu_result_i),
        .fu_ex_i       (fu_ex_i),
        .fu_ready_o    (fu_ready_o),
        .wb_valid_o    (wb_valid_o),
        .wb_trans_id_o (wb_trans_id_o),
        .wb_result_o   (wb_result_o),
        .wb_ex_o       (wb_ex_o),
        .wb_ready_i    (wb_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] tid;
        logic [63:0]              res;
        exception_t               ex;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests_run = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    function automatic exception_t mk_ex(input logic [63:0] res);
        exception_t e;
        e.cause = ~res;
        e.tval  = {res[59:0], 4'h0};
        e.valid = res[0];
        return e;
    endfunction

    task automatic drive(input int p, input logic [TRANS_ID_BITS-1:0] tid,
                         input logic [63:0] res, input bit push);
        exp_t e;
        fu_valid_i[p]    = 1'b1;
        fu_trans_id_i[p] = tid;
        fu_result_i[p]   = res;
        fu_ex_i[p]       = mk_ex(res);
        if (push) begin
            e.tid = tid;
            e.res = res;
            e.ex  = mk_ex(res);
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard: every accepted writeback must match the oldest expected entry.
    always @(negedge clk_i) begin
        if (mon_en && rst_ni) begin
            if (wb_valid_o && wb_ready_i) begin
                tests_run++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL wb_unexpected: got tid=%0d result=%h, expected no writeback",
                             wb_trans_id_o, wb_result_o);
                end else begin
                    mon_e = sb.pop_front();
                    if ({wb_trans_id_o, wb_result_o, wb_ex_o} !== {mon_e.tid, mon_e.res, mon_e.ex}) begin
                        fails++;
                        $display("FAIL wb_data: got tid=%0d result=%h ex=%h, expected tid=%0d result=%h ex=%h",
                                 wb_trans_id_o, wb_result_o, wb_ex_o, mon_e.tid, mon_e.res, mon_e.ex);
                    end
                end
            end else if (!wb_valid_o) begin
                tests_run++;
                if (wb_trans_id_o !== '0 || wb_result_o !== '0 || wb_ex_o !== '0) begin
                    fails++;
                    $display("FAIL wb_idle_zero: got tid=%0d result=%h, expected 0 0",
                             wb_trans_id_o, wb_result_o);
                end
            end
        end
    end

    task automatic test_reset();
        #2;
        tests_run++;
        if (wb_valid_o !== 1'b0 || fu_ready_o !== {N{1'b1}} || wb_trans_id_o !== '0
            || wb_result_o !== '0 || wb_ex_o !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b ready=%b tid=%0d res=%h, expected 0 111 0 0",
                     wb_valid_o, fu_ready_o, wb_trans_id_o, wb_result_o);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step();
        @(negedge clk_i);
        tests_run++;
        if (wb_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got valid=%b, expected 0", wb_valid_o);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_all_three();
        wb_ready_i = 1'b1;
        drive(0, 3'd1, 64'h10, 1'b1);
        drive(1, 3'd2, 64'h20, 1'b1);
        drive(2, 3'd3, 64'h30, 1'b1);
        step();
        fu_valid_i = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            tests_run++;
            if (wb_valid_o !== 1'b1) begin
                fails++;
                $display("FAIL all3_valid_cycle%0d: got valid=%b, expected 1", k, wb_valid_o);
            end
        end
        @(negedge clk_i);
        #1;
        tests_run++;
        if (wb_valid_o !== 1'b0 || sb.size() != 0) begin
            fails++;
            $display("FAIL all3_drain: got valid=%b pending=%0d, expected 0 0", wb_valid_o, sb.size());
        end
        // Pointer must be back at 0: port 0 wins over port 2.
        step();
        drive(0, 3'd5, 64'h50, 1'b1);
        drive(2, 3'd4, 64'h40, 1'b1);
        step();
        fu_valid_i = '0;
        repeat (3) @(negedge clk_i);
        #1;
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL rr_ptr_wrap: got pending=%0d, expected 0", sb.size());
        end
    endtask

    task automatic test_single();
        step();
        wb_ready_i = 1'b1;
        drive(1, 3'd2, 64'hDEAD, 1'b1);
        step();
        fu_valid_i = '0;
        @(negedge clk_i);
        tests_run++;
        if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 3'd2 || wb_result_o !== 64'hDEAD) begin
            fails++;
            $display("FAIL single_wb: got valid=%b tid=%0d res=%h, expected 1 2 dead",
                     wb_valid_o, wb_trans_id_o, wb_result_o);
        end
        @(negedge clk_i);
        #1;
        tests_run++;
        if (wb_valid_o !== 1'b0 || sb.size() != 0) begin
            fails++;
            $display("FAIL single_after: got valid=%b pending=%0d, expected 0 0", wb_valid_o, sb.size());
        end
    endtask

    task automatic test_backpressure();
        step();
        wb_ready_i = 1'b0;
        drive(0, 3'd5, 64'h1111, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(0, 3'd6, 64'h2222, 1'b0);
            if (i == 1) drive(2, 3'd7, 64'h7777, 1'b1);
            if (i == 2) fu_valid_i[2] = 1'b0;
            @(negedge clk_i);
            tests_run++;
            if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 3'd5 || wb_result_o !== 64'h1111
                || fu_ready_o[0] !== 1'b0) begin
                fails++;
                $display("FAIL backpressure_hold%0d: got valid=%b tid=%0d res=%h rdy0=%b, expected 1 5 1111 0",
                         i, wb_valid_o, wb_trans_id_o, wb_result_o, fu_ready_o[0]);
            end
            step();
        end
        fu_valid_i = '0;
        wb_ready_i = 1'b1;
        @(negedge clk_i);
        tests_run++;
        if (wb_trans_id_o !== 3'd5) begin
            fails++;
            $display("FAIL backpressure_release: got tid=%0d, expected 5", wb_trans_id_o);
        end
        @(negedge clk_i);
        tests_run++;
        if (wb_trans_id_o !== 3'd7) begin
            fails++;
            $display("FAIL backpressure_next: got tid=%0d, expected 7", wb_trans_id_o);
        end
        @(negedge clk_i);
        #1;
        tests_run++;
        if (wb_valid_o !== 1'b0 || sb.size() != 0) begin
            fails++;
            $display("FAIL backpressure_drain: got valid=%b pending=%0d, expected 0 0",
                     wb_valid_o, sb.size());
        end
    endtask

    task automatic test_refill();
        step();
        wb_ready_i = 1'b0;
        drive(2, 3'd4, 64'hA4, 1'b1);
        step();
        wb_ready_i = 1'b1;
        drive(2, 3'd3, 64'hB3, 1'b1);
        @(negedge clk_i);
        tests_run++;
        if (fu_ready_o[2] !== 1'b1 || wb_trans_id_o !== 3'd4) begin
            fails++;
            $display("FAIL refill_ready: got rdy2=%b tid=%0d, expected 1 4", fu_ready_o[2], wb_trans_id_o);
        end
        step();
        fu_valid_i = '0;
        @(negedge clk_i);
        tests_run++;
        if (wb_valid_o !== 1'b1 || wb_trans_id_o !== 3'd3) begin
            fails++;
            $display("FAIL refill_next: got valid=%b tid=%0d, expected 1 3", wb_valid_o, wb_trans_id_o);
        end
        @(negedge clk_i);
        #1;
        tests_run++;
        if (wb_valid_o !== 1'b0 || sb.size() != 0) begin
            fails++;
            $display("FAIL refill_drain: got valid=%b pending=%0d, expected 0 0", wb_valid_o, sb.size());
        end
    endtask

    task automatic test_flush();
        step();
        wb_ready_i = 1'b0;
        drive(0, 3'd1, 64'h1, 1'b0);
        drive(2, 3'd2, 64'h2, 1'b0);
        step();
        fu_valid_i = '0;
        flush_i = 1'b1;
        drive(1, 3'd3, 64'h3, 1'b0);
        step();
        flush_i    = 1'b0;
        fu_valid_i = '0;
        wb_ready_i = 1'b1;
        @(negedge clk_i);
        tests_run++;
        if (wb_valid_o !== 1'b0 || fu_ready_o !== {N{1'b1}}) begin
            fails++;
            $display("FAIL flush_clear: got valid=%b ready=%b, expected 0 111", wb_valid_o, fu_ready_o);
        end
        step();
        @(negedge clk_i);
        tests_run++;
        if (wb_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL flush_drop_input: got valid=%b, expected 0", wb_valid_o);
        end
    endtask

    task automatic test_prio();
        logic [TRANS_ID_BITS-1:0] exp_tid;
        mon_en = 1'b0;
        step();
        wb_ready_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k < 6) begin
                drive(0, 3'd0, 64'h100 + 64'(k), 1'b0);
                drive(1, 3'd1, 64'h200, 1'b0);
            end else begin
                fu_valid_i = '0;
            end
            if (k >= 1) begin
`ifdef WB_ARB_FIXED_PRIO_EN
                exp_tid = 3'd0;
`else
                exp_tid = (k % 2 == 1) ? 3'd0 : 3'd1;
`endif
                @(negedge clk_i);
                tests_run++;
                if (wb_valid_o !== 1'b1 || wb_trans_id_o !== exp_tid) begin
                    fails++;
                    $display("FAIL prio_grant%0d: got valid=%b tid=%0d, expected 1 %0d",
                             k, wb_valid_o, wb_trans_id_o, exp_tid);
                end
            end
            step();
        end
        fu_valid_i = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (!wb_valid_o) break;
        end
        tests_run++;
        if (wb_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL prio_drain: got valid=%b, expected 0", wb_valid_o);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        step();
        wb_ready_i = 1'b0;
        drive(1, 3'd5, 64'h55, 1'b0);
        step();
        fu_valid_i = '0;
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if (wb_valid_o !== 1'b0 || fu_ready_o !== {N{1'b1}} || wb_trans_id_o !== '0) begin
            fails++;
            $display("FAIL reset_async: got valid=%b ready=%b tid=%0d, expected 0 111 0",
                     wb_valid_o, fu_ready_o, wb_trans_id_o);
        end
        @(posedge clk_i);
        #1;
        rst_ni     = 1'b1;
        wb_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            tests_run++;
            if (wb_valid_o !== 1'b0) begin
                fails++;
                $display("FAIL reset_drop%0d: got valid=%b, expected 0", k, wb_valid_o);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        wb_ready_i    = 1'b1;
        fu_valid_i    = '0;
        fu_trans_id_i = '0;
        fu_result_i   = '0;
        fu_ex_i       = '0;
        test_reset();
        test_all_three();
        test_single();
        test_backpressure();
        test_refill();
        test_flush();
        test_prio();
        test_reset_mid();
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got pending=%0d, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
